regfile_wb_arbiter: RTL and testbench

Sequencer and arbiter for the single write port (a3/write_data/write_enable) of the 32x32 register file.
- After reset it clears x1..x31 to zero.
- It then shares the write port between two writeback requesters (req0 = ALU writeback, req1 = load/auxiliary writeback) using round-robin arbitration and a valid/ready handshake.
- Write-port outputs are registered and connect directly to the register file.

---
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Owns the single write port of the 32x32 register file. After reset it
// optionally zero-clears x1..x31, then shares the port between two writeback
// requesters with round-robin arbitration over a valid/ready handshake.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req0_valid/addr/data/ready      requester 0 (ALU writeback)
//   req1_valid/addr/data/ready      requester 1 (load/auxiliary writeback)
//   rf_we, rf_a3, rf_wd             registered write port to the register file
//   init_done                       high once the clear sequence has finished
//   stall_cnt                       saturating count of valid-but-unaccepted cycles
module regfile_wb_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic [4:0]             req0_addr,
    input  logic [31:0]            req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [4:0]             req1_addr,
    input  logic [31:0]            req1_data,
    output logic                   req1_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_a3,
    output logic [31:0]            rf_wd,
    output logic                   init_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [4:0]             clr;
    logic                   last_grant;
    logic                   grant0;
    logic                   grant1;
    logic [1:0]             stall_inc;
    logic [STALL_CNT_W:0]   stall_sum;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET)
                state <= ST_INIT;
            else
                state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and grant decode
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            ST_INIT: begin
                if (clr == 5'd31)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                // Nothing is accepted in a reset cycle: its write would be discarded.
                if (!reset) begin
                    if (req0_valid && (!req1_valid || last_grant))
                        grant0 = 1'b1;
                    else if (req1_valid)
                        grant1 = 1'b1;
                end
            end
            default: state_next = state;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // One extra bit catches overflow so the counter can clamp at all-ones.
    always_comb begin
        stall_inc = {1'b0, req0_valid && !grant0} + {1'b0, req1_valid && !grant1};
        stall_sum = {1'b0, stall_cnt} + (STALL_CNT_W + 1)'(stall_inc);
    end

    // Registered write port, clear counter, arbitration history, stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_a3      <= '0;
            rf_wd      <= '0;
            init_done  <= 1'b0;
            stall_cnt  <= '0;
            last_grant <= 1'b1;
            clr        <= 5'd1;
        end else begin
            init_done <= (state_next == ST_RUN);

            if (stall_sum[STALL_CNT_W])
                stall_cnt <= '1;
            else
                stall_cnt <= stall_sum[STALL_CNT_W-1:0];

            case (state)
                ST_INIT: begin
                    rf_we <= 1'b1;
                    rf_a3 <= clr;
                    rf_wd <= '0;
                    if (clr != 5'd31)
                        clr <= clr + 5'd1;
                end
                ST_RUN: begin
                    // Writes to x0 are accepted but never reach the register file.
                    if (grant0) begin
                        rf_we      <= (req0_addr != 5'd0);
                        rf_a3      <= req0_addr;
                        rf_wd      <= req0_data;
                        last_grant <= 1'b0;
                    end else if (grant1) begin
                        rf_we      <= (req1_addr != 5'd0);
                        rf_a3      <= req1_addr;
                        rf_wd      <= req1_data;
                        last_grant <= 1'b1;
                    end else begin
                        rf_we <= 1'b0;
                    end
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: scoreboard of expected register-file
// writes checked by a monitor on every registered write, plus directed checks
// of ready, init_done and stall_cnt. A second instance with a 4-bit stall
// counter shares the stimulus to exercise saturation.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;

    logic        req0_ready, req1_ready, rf_we, init_done;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [15:0] stall_cnt;

    logic        s_req0_ready, s_req1_ready, s_rf_we, s_init_done;
    logic [4:0]  s_rf_a3;
    logic [31:0] s_rf_wd;
    logic [3:0]  s_stall_cnt;

    wr_t         exp_q[$];
    logic [31:0] model[32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b1), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .init_done(init_done), .stall_cnt(stall_cnt)
    );

    regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b1), .STALL_CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_req1_ready),
        .rf_we(s_rf_we), .rf_a3(s_rf_a3), .rf_wd(s_rf_wd),
        .init_done(s_init_done), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 1; i < 32; i++) push(5'(i), 32'h0);
    endtask

    // Monitor: every registered write must match the next expected entry.
    always @(negedge clk) begin
        wr_t e;
        if (rf_we || s_rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got a3=%0d wd=%0h expected no write", rf_a3, rf_wd);
            end else begin
                e = exp_q.pop_front();
                chk("wr_en",       {31'd0, rf_we},    32'd1);
                chk("wr_addr",     {27'd0, rf_a3},    {27'd0, e.addr});
                chk("wr_data",     rf_wd,             e.data);
                chk("sat_wr_en",   {31'd0, s_rf_we},  32'd1);
                chk("sat_wr_addr", {27'd0, s_rf_a3},  {27'd0, e.addr});
                chk("sat_wr_data", s_rf_wd,           e.data);
                if (rf_we && rf_a3 != 5'd0) model[rf_a3] = rf_wd;
            end
        end
    end

    // Called at posedge+1; drives one cycle, checks readies, records accepted writes.
    task automatic req(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic er0, input logic er1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
        if (er0 && a0 != 5'd0) push(a0, d0);
        if (er1 && a1 != 5'd0) push(a1, d1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hFFFF_FFFF;
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset values
        @(negedge clk);
        chk("rst_rf_we",     {31'd0, rf_we},     32'd0);
        chk("rst_rf_a3",     {27'd0, rf_a3},     32'd0);
        chk("rst_rf_wd",     rf_wd,              32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_stall",     {16'd0, stall_cnt}, 32'd0);

        // Clear sequence with both requesters stalled for 20 cycles
        @(posedge clk); #1;
        push_clear();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h77;
        @(negedge clk);
        chk("init_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("init_req1_ready", {31'd0, req1_ready}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("init_stall",     {16'd0, stall_cnt},  32'd40);
        chk("sat_stall",      {28'd0, s_stall_cnt}, 32'd15);
        chk("init_done_low",  {31'd0, init_done},  32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("init_done_e30",  {31'd0, init_done},  32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("init_done_e31",  {31'd0, init_done},  32'd1);
        chk("sat_init_done",  {31'd0, s_init_done}, 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i < 32; i++) chk("clear_readback", model[i], 32'h0);

        // Round robin under contention, req0 first
        req(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0);
        req(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1);
        req(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0);
        req(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1);
        idle(2);
        chk("rr_stall", {16'd0, stall_cnt}, 32'd44);
        chk("rr_x1",    model[1], 32'h11);
        chk("rr_x2",    model[2], 32'h22);

        // Single requesters
        req(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        req(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1);
        idle(2);
        chk("single_x5", model[5], 32'hDEAD_BEEF);
        chk("single_x6", model[6], 32'h66);

        // Same-address collision: req0 wins, req1 lands second
        req(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 1'b0);
        req(1'b0, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0, 1'b1);
        idle(2);
        chk("collide_x7",    model[7], 32'hB);
        chk("collide_stall", {16'd0, stall_cnt}, 32'd45);

        // Write to x0 is accepted but not issued
        req(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("x0_rf_we", {31'd0, rf_we}, 32'd0);

        // Reset with a RUN request pending
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("runrst_rf_we",     {31'd0, rf_we},      32'd0);
        chk("runrst_stall",     {16'd0, stall_cnt},  32'd0);
        chk("runrst_sat_stall", {28'd0, s_stall_cnt}, 32'd0);
        chk("runrst_init_done", {31'd0, init_done},  32'd0);

        // Reset again while INIT is at clr=10
        @(posedge clk); #1;
        for (int i = 1; i < 10; i++) push(5'(i), 32'h0);
        reset = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        push_clear();
        @(negedge clk);
        chk("initrst_rf_we", {31'd0, rf_we},     32'd0);
        chk("initrst_rf_a3", {27'd0, rf_a3},     32'd0);
        chk("initrst_stall", {16'd0, stall_cnt}, 32'd0);
        repeat (31) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reinit_done", {31'd0, init_done}, 32'd1);
        @(posedge clk); #1;
        chk("reclear_x5", model[5], 32'h0);
        chk("reclear_x7", model[7], 32'h0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
